// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with held, non-preemptive grants and registered outputs.
// Optional hold timeout is built in when RR_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic       pick_vld;
    logic [1:0] pick_idx;
    logic       hold_done;
    logic       release_w;

    // Scan from the far end so the requester closest to ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr_q + 2'(k);
            end
        end
    end

    assign release_w = (state_q == GRANT) && (!req[idx_q] || hold_done);

`ifdef RR_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hold_done = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == GRANT && !release_w) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{MAX_HOLD[0], CNT_W[0]};
    assign hold_done  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_vld) state_d = GRANT;
            GRANT:   if (release_w) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = 4'b0001 << pick_idx;
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (release_w) begin
                    gnt_d   = 4'b0000;
                    idx_d   = 2'd0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                idx_d   = 2'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4; a reference model pushes expected outputs per cycle.
module tb_rr_arbiter_4;

    localparam int MH = 4;
`ifdef RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    exp_t sb[$];
    int   order[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bit   m_busy = 1'b0;
    int   m_own  = 0;
    int   m_ptr  = 0;
    int   m_cnt  = 0;
    logic prev_v = 1'b0;

    rr_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, act, exp_v, $time);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq);
        exp_t e;
        exp_t o;
        bit   found;
        rst = r;
        req = rq;
        if (r) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && rq[(m_ptr + k) % 4]) begin
                    found  = 1'b1;
                    m_busy = 1'b1;
                    m_own  = (m_ptr + k) % 4;
                    m_cnt  = 0;
                end
            end
        end else begin
            m_cnt++;
            if (!rq[m_own] || (TO_EN && m_cnt == MH)) begin
                m_busy = 1'b0;
                m_ptr  = (m_own + 1) % 4;
                m_cnt  = 0;
            end
        end
        e.g = m_busy ? (4'b0001 << m_own) : 4'b0000;
        e.i = m_busy ? 2'(m_own) : 2'd0;
        e.v = m_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("gnt", gnt, o.g);
        chk("gnt_idx", gnt_idx, o.i);
        chk("gnt_valid", gnt_valid, o.v);
        chk("onehot", 32'($countones(gnt) <= 1), 1);
        if (gnt_valid && !prev_v) order.push_back(int'(gnt_idx));
        prev_v = gnt_valid;
    endtask

    initial begin
        int c0;
        bit done;
        int rot_exp[5];
        logic [3:0] rq;
        rot_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req = 4'b1111;

        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_gnt", gnt, 0);

        step(1'b0, 4'b0001);
        chk("single_gnt", gnt, 4'b0001);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        chk("single_rel", gnt_valid, 0);
        step(1'b0, 4'b0000);

        step(1'b1, 4'b0000);
        order.delete();
        for (int n = 0; n < 40 && order.size() < 5; n++) begin
            rq = 4'b1111;
            if (m_busy && m_cnt == 2) rq[m_own] = 1'b0;
            step(1'b0, rq);
        end
        chk("rot_count", order.size(), 5);
        for (int n = 0; n < 5 && n < order.size(); n++)
            chk("rot_order", order[n], rot_exp[n]);

        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b1001);
        chk("wrap_idx", gnt_idx, 3);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0001);
        chk("wrap_next", gnt_idx, 0);
        step(1'b0, 4'b0000);

        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0110);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 4'b0011);
            chk("nopreempt", gnt, 4'b0010);
        end
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0001);
        chk("after_owner", gnt_idx, 0);

        step(1'b0, 4'b0001);
        step(1'b1, 4'b0001);
        chk("rst_mid", gnt_valid, 0);

        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        chk("one_cycle", gnt_valid, 0);

        step(1'b1, 4'b0000);
        c0   = 0;
        done = 1'b0;
        for (int n = 0; n < 14; n++) begin
            step(1'b0, 4'b0011);
            if (!done) begin
                if (gnt_valid && gnt_idx == 2'd0) c0++;
                else if (c0 > 0) done = 1'b1;
            end
        end
        chk("hold_len", c0, TO_EN ? MH : 14);

        for (int n = 0; n < 300; n++)
            step(($urandom_range(0, 39) == 0), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
